pattern_generator: RTL and testbench
====================================

// Module: pattern_generator
// PURPOSE
//  Programmable multi-mode stimulus source for logic-analyzer bring-up and self-test.
//  Drives NUM_CHANNELS test signals into the capture path.
//  Modes: binary count, walking one, toggle, and (optional) LFSR pseudo-random.
//  Update rate comes from a runtime-programmable prescaler instead of a fixed divider.
//  Runtime config is latched atomically; a strobe marks every pattern update for trigger/debug.
// PARAMETERS
//  NUM_CHANNELS  16       width of generated pattern (>=2)
//  DIV_BITS      15       prescaler width; max period 2^DIV_BITS clocks
//  LFSR_TAPS     16'hB400 Galois feedback mask, NUM_CHANNELS wide (LFSR mode only)
// PORTS
//  clk           in   1             clock
//  reset         in   1             synchronous, active-high
//  enable        in   1             1 = run, 0 = freeze prescaler and pattern
//  cfg_load      in   1             1-cycle pulse: latch cfg_mode/cfg_divisor/cfg_seed
//  cfg_mode      in   2             0 count, 1 walking-one, 2 toggle, 3 LFSR
//  cfg_divisor   in   DIV_BITS      update every cfg_divisor+1 clocks
//  cfg_seed      in   NUM_CHANNELS  initial pattern loaded with cfg_load
//  chanSignals   out  NUM_CHANNELS  generated pattern, registered
//  update_strobe out  1             high for exactly the cycle chanSignals takes a tick update
//  wrap          out  1             high with update_strobe when the sequence wraps
// BEHAVIOUR
//  Clock: clk. Reset: reset, synchronous, active-high.
//  - Reset values: chanSignals=0, update_strobe=0, wrap=0, mode=0, divisor=all-ones, prescaler=0.
//    With these values, behaviour after reset equals a plain 2^DIV_BITS-period binary counter.
//  - Prescaler counts 0..divisor. When enable=1 and prescaler==divisor: tick, prescaler<=0.
//    Otherwise prescaler increments. divisor=0 gives a tick every enabled cycle.
//  - On tick (registered, same edge), chanSignals updates per latched mode:
//      count: +1 mod 2^NUM_CHANNELS. wrap when old value is all-ones.
//      walking-one: rotate left by 1. If old value is 0, load 1. wrap when old MSB=1.
//      toggle: bitwise invert. wrap on every second update (value returns to seed).
//      LFSR: Galois shift right, XOR LFSR_TAPS if old LSB=1. Old value 0 -> load 1.
//        wrap when new value equals latched seed (or 1 if seed was 0).
//  - update_strobe and wrap are registered. They are asserted in the same cycle the new
//    chanSignals value is visible and deasserted the next cycle unless another tick occurs.
//  - cfg_load has priority over tick and enable:
//      latch mode/divisor/seed; chanSignals<=cfg_seed; prescaler<=0;
//      update_strobe=0, wrap=0 that cycle.
//    The first tick occurs divisor+1 enabled cycles after the load.
//  - enable=0: prescaler, chanSignals and latched config hold. strobe/wrap deassert.
//    cfg_load is still honoured.
//  - Config is used only in latched form; changing cfg_* without cfg_load has no effect.
//  - reset mid-period: all state returns to reset values next cycle, with no partial update.
// CONFIGURATION
//  Macro PATTERN_GEN_LFSR_EN.
//  - Defined: mode 3 = LFSR as above. LFSR_TAPS is used.
//  - Undefined: no LFSR logic is built. Mode 3 holds chanSignals at the loaded seed.
//    In mode 3 the prescaler still runs, but update_strobe and wrap stay 0.
// TESTING
//  1 reset, enable=1, no cfg_load, DIV_BITS=4 -> chanSignals 0->1 after 16 clks.
//    update_strobe is 1 clk wide every 16 clks.
//  2 cfg_load mode=0, divisor=0, seed=16'hFFFE -> FFFF next clk, then 0000 with wrap=1.
//    strobe stays high every cycle.
//  3 cfg_load mode=1, divisor=2, seed=0 -> 0001, 0002, 0004 ... at 3-clk spacing.
//    8000->0001 asserts wrap.
//  4 mode=2, seed=16'hA5A5, divisor=1 -> 5A5A, A5A5 alternating every 2 clks.
//    wrap asserted on each A5A5.
//  5 enable low 10 clks mid-period, then high -> pattern/prescaler resume exactly.
//    No strobe during the freeze. A cfg_load during the freeze reloads the seed.
//  6 mode=3, seed=1, divisor=0: with PATTERN_GEN_LFSR_EN -> 2^16-1 distinct values, then wrap.
//    Without the macro -> chanSignals stays 0001 and strobe stays 0.

Source files
------------

// File: rtl/pattern_generator.sv
// pattern_generator
//   Programmable multi-mode stimulus source for logic-analyzer bring-up and
//   self-test. It drives NUM_CHANNELS test signals, updated on ticks of a
//   runtime-programmable prescaler.
//
//   Modes (latched cfg_mode):
//     0 binary count, 1 walking one, 2 toggle, 3 LFSR (optional).
//
//   Build option:
//     PATTERN_GEN_LFSR_EN  defined   -> mode 3 is a Galois LFSR using LFSR_TAPS.
//                          undefined -> no LFSR logic is built. Mode 3 holds the
//                                       loaded seed. The prescaler keeps running,
//                                       but no update_strobe or wrap is produced.
//
//   Ports:
//     clk            clock
//     reset          synchronous, active-high
//     enable         1 = run, 0 = freeze prescaler and pattern
//     cfg_load       1-cycle pulse: latch cfg_mode/cfg_divisor/cfg_seed, load seed
//     cfg_mode       pattern mode
//     cfg_divisor    update every cfg_divisor+1 enabled clocks
//     cfg_seed       initial pattern loaded with cfg_load
//     chanSignals    generated pattern (registered)
//     update_strobe  high for exactly the cycle chanSignals shows a tick update
//     wrap           high with update_strobe when the sequence wraps

// Per-channel next-state slice. Each lane sees only its own bit, its
// neighbours, and a few shared terms computed once at the top level.
module pattern_generator_lane (
    input  logic [1:0] mode,
    input  logic       cur,       // this channel's current bit
    input  logic       lower,     // next lower bit (rotated: lane 0 sees MSB)
    input  logic       upper,     // next higher bit (0 for the MSB lane)
    input  logic       lsb,       // current bit 0, selects LFSR feedback
    input  logic       carry,     // all lower bits are one (count increment)
    input  logic       tap,       // LFSR feedback mask bit for this lane
    input  logic       seed_one,  // lane 0 with an all-zero pattern: force a 1 in
    output logic       nxt
);
    always_comb begin
        nxt = cur;
        case (mode)
            2'd0: nxt = cur ^ carry;
            // With an all-zero pattern every lower bit is 0, so only lane 0
            // picks up seed_one and the result is 1.
            2'd1: nxt = lower | seed_one;
            2'd2: nxt = ~cur;
            default: begin
`ifdef PATTERN_GEN_LFSR_EN
                nxt = (upper ^ (tap & lsb)) | seed_one;
`else
                nxt = cur;
`endif
            end
        endcase
    end

`ifndef PATTERN_GEN_LFSR_EN
    logic unused_lfsr_inputs;
    assign unused_lfsr_inputs = upper ^ tap ^ lsb;
`endif
endmodule

module pattern_generator #(
    parameter int                      NUM_CHANNELS = 16,
    parameter int                      DIV_BITS     = 15,
    parameter logic [NUM_CHANNELS-1:0] LFSR_TAPS    = 16'hB400
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    cfg_load,
    input  logic [1:0]              cfg_mode,
    input  logic [DIV_BITS-1:0]     cfg_divisor,
    input  logic [NUM_CHANNELS-1:0] cfg_seed,
    output logic [NUM_CHANNELS-1:0] chanSignals,
    output logic                    update_strobe,
    output logic                    wrap
);
    localparam logic [NUM_CHANNELS-1:0] ONE = NUM_CHANNELS'(1);

    // Latched configuration
    logic [1:0]              mode_q;
    logic [DIV_BITS-1:0]     div_q;
    logic [NUM_CHANNELS-1:0] seed_q;
    logic [DIV_BITS-1:0]     presc;

    logic [NUM_CHANNELS-1:0] nxt;
    logic [NUM_CHANNELS:0]   carry;
    logic                    cur_zero;
    logic                    tick;
    logic                    upd_en;
    logic                    wrap_c;

    assign cur_zero = (chanSignals == '0);
    assign tick     = enable && (presc == div_q);

    // Without the LFSR, mode 3 keeps the prescaler running but never updates.
`ifdef PATTERN_GEN_LFSR_EN
    assign upd_en = 1'b1;
`else
    assign upd_en = (mode_q != 2'd3);
    logic unused_taps;
    assign unused_taps = ^LFSR_TAPS;
`endif

    // Increment carry chain for count mode.
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < NUM_CHANNELS; i++) begin : g_lane
            logic lower_b, upper_b;
            if (i == 0) begin : g_lo
                assign lower_b = chanSignals[NUM_CHANNELS-1];
            end else begin : g_lo
                assign lower_b = chanSignals[i-1];
            end
            if (i == NUM_CHANNELS - 1) begin : g_up
                assign upper_b = 1'b0;
            end else begin : g_up
                assign upper_b = chanSignals[i+1];
            end
            assign carry[i+1] = carry[i] & chanSignals[i];

            pattern_generator_lane u_lane (
                .mode     (mode_q),
                .cur      (chanSignals[i]),
                .lower    (lower_b),
                .upper    (upper_b),
                .lsb      (chanSignals[0]),
                .carry    (carry[i]),
                .tap      (LFSR_TAPS[i]),
                .seed_one ((i == 0) && cur_zero),
                .nxt      (nxt[i])
            );
        end
    endgenerate

    // Wrap detection, evaluated against the value being replaced (or its successor).
    always_comb begin
        wrap_c = 1'b0;
        case (mode_q)
            2'd0: wrap_c = carry[NUM_CHANNELS];            // old value all ones
            2'd1: wrap_c = chanSignals[NUM_CHANNELS-1];    // MSB rotates out
            2'd2: wrap_c = (nxt == seed_q);                // every second inversion
            default: begin
`ifdef PATTERN_GEN_LFSR_EN
                // A zero seed can never recur in the LFSR, so the cycle restarts at 1.
                wrap_c = (nxt == ((seed_q == '0) ? ONE : seed_q));
`else
                wrap_c = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q        <= 2'd0;
            div_q         <= '1;
            seed_q        <= '0;
            presc         <= '0;
            chanSignals   <= '0;
            update_strobe <= 1'b0;
            wrap          <= 1'b0;
        end else if (cfg_load) begin
            mode_q        <= cfg_mode;
            div_q         <= cfg_divisor;
            seed_q        <= cfg_seed;
            presc         <= '0;
            chanSignals   <= cfg_seed;
            update_strobe <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            update_strobe <= 1'b0;
            wrap          <= 1'b0;
            if (tick) begin
                presc <= '0;
                if (upd_en) begin
                    chanSignals   <= nxt;
                    update_strobe <= 1'b1;
                    wrap          <= wrap_c;
                end
            end else if (enable) begin
                presc <= presc + DIV_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_pattern_generator.sv
module tb_pattern_generator;
    localparam int N  = 16;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset, enable, cfg_load;
    logic [1:0]    cfg_mode;
    logic [DB-1:0] cfg_divisor;
    logic [N-1:0]  cfg_seed;
    logic [N-1:0]  chanSignals;
    logic          update_strobe, wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_generator #(.NUM_CHANNELS(N), .DIV_BITS(DB), .LFSR_TAPS(16'hB400)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
        .cfg_mode(cfg_mode), .cfg_divisor(cfg_divisor), .cfg_seed(cfg_seed),
        .chanSignals(chanSignals), .update_strobe(update_strobe), .wrap(wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle #1 so outputs are sampled away from the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [1:0] m, input logic [DB-1:0] d, input logic [N-1:0] s);
        cfg_mode = m; cfg_divisor = d; cfg_seed = s; cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
    endtask

    initial begin
        int strobes;
        reset = 1'b1; enable = 1'b1; cfg_load = 1'b0;
        cfg_mode = 2'd0; cfg_divisor = '0; cfg_seed = '0;
        step(2);
        reset = 1'b0;

        // 1: reset state, then default 16-clock binary count
        chk("rst_chan", chanSignals, 0);
        chk("rst_strobe", update_strobe, 0);
        chk("rst_wrap", wrap, 0);
        step(15);
        chk("t1_before_tick", chanSignals, 0);
        chk("t1_no_strobe", update_strobe, 0);
        step(1);
        chk("t1_first", chanSignals, 1);
        chk("t1_strobe", update_strobe, 1);
        step(1);
        chk("t1_strobe_1clk", update_strobe, 0);
        step(15);
        chk("t1_second", chanSignals, 2);
        chk("t1_strobe2", update_strobe, 1);

        // 2: count wrap at divisor 0
        load(2'd0, 4'd0, 16'hFFFE);
        chk("t2_load", chanSignals, 16'hFFFE);
        chk("t2_load_strobe", update_strobe, 0);
        step(1);
        chk("t2_ffff", chanSignals, 16'hFFFF);
        chk("t2_ffff_wrap", wrap, 0);
        chk("t2_ffff_strobe", update_strobe, 1);
        step(1);
        chk("t2_zero", chanSignals, 16'h0000);
        chk("t2_zero_wrap", wrap, 1);
        chk("t2_zero_strobe", update_strobe, 1);
        // Config inputs changed without cfg_load have no effect
        cfg_mode = 2'd2; cfg_divisor = 4'd5; cfg_seed = 16'h1234;
        step(1);
        chk("t2_one", chanSignals, 16'h0001);
        chk("t2_one_wrap", wrap, 0);
        chk("t2_one_strobe", update_strobe, 1);

        // 3: walking one from zero seed, 3-clock spacing
        load(2'd1, 4'd2, 16'h0000);
        step(2);
        chk("t3_wait", chanSignals, 0);
        chk("t3_wait_strobe", update_strobe, 0);
        step(1);
        chk("t3_first", chanSignals, 16'h0001);
        chk("t3_first_wrap", wrap, 0);
        for (int k = 1; k < 16; k++) begin
            step(3);
            chk("t3_walk", chanSignals, 32'(1) << k);
            chk("t3_walk_wrap", wrap, 0);
        end
        step(3);
        chk("t3_wrap_val", chanSignals, 16'h0001);
        chk("t3_wrap", wrap, 1);

        // 4: toggle
        load(2'd2, 4'd1, 16'hA5A5);
        step(1);
        chk("t4_hold", chanSignals, 16'hA5A5);
        step(1);
        chk("t4_inv", chanSignals, 16'h5A5A);
        chk("t4_inv_wrap", wrap, 0);
        step(2);
        chk("t4_back", chanSignals, 16'hA5A5);
        chk("t4_back_wrap", wrap, 1);
        step(2);
        chk("t4_inv2", chanSignals, 16'h5A5A);
        chk("t4_inv2_wrap", wrap, 0);

        // 5: freeze mid-period, then load during a freeze
        load(2'd0, 4'd3, 16'h0010);
        step(2);
        enable = 1'b0;
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (update_strobe) strobes++;
        end
        chk("t5_freeze_val", chanSignals, 16'h0010);
        chk("t5_freeze_strobes", strobes, 0);
        enable = 1'b1;
        step(1);
        chk("t5_resume_pre", chanSignals, 16'h0010);
        chk("t5_resume_pre_strobe", update_strobe, 0);
        step(1);
        chk("t5_resume_tick", chanSignals, 16'h0011);
        chk("t5_resume_strobe", update_strobe, 1);
        enable = 1'b0;
        load(2'd0, 4'd0, 16'h1234);
        chk("t5_frozen_load", chanSignals, 16'h1234);
        step(3);
        chk("t5_frozen_hold", chanSignals, 16'h1234);
        chk("t5_frozen_strobe", update_strobe, 0);
        enable = 1'b1;
        step(1);
        chk("t5_after", chanSignals, 16'h1235);

        // 6: mode 3
        load(2'd3, 4'd0, 16'h0001);
`ifdef PATTERN_GEN_LFSR_EN
        begin
            int wraps_early;
            step(1);
            chk("t6_lfsr_first", chanSignals, 16'hB400);
            wraps_early = 0;
            for (int k = 1; k < 65534; k++) begin
                step(1);
                if (wrap || chanSignals == 16'h0001) wraps_early++;
            end
            chk("t6_lfsr_early", wraps_early, 0);
            step(1);
            chk("t6_lfsr_period", chanSignals, 16'h0001);
            chk("t6_lfsr_wrap", wrap, 1);
        end
`else
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (update_strobe || wrap) strobes++;
        end
        chk("t6_hold", chanSignals, 16'h0001);
        chk("t6_no_strobe", strobes, 0);
`endif

        // Reset mid-period restores defaults with no partial update
        load(2'd0, 4'd3, 16'h00F0);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst2_chan", chanSignals, 0);
        chk("rst2_strobe", update_strobe, 0);
        step(15);
        chk("rst2_period_pre", chanSignals, 0);
        step(1);
        chk("rst2_period", chanSignals, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
